pong_game_sequencer: RTL
========================

Name: pong_game_sequencer

Overview:
Central game-flow controller for the Pong datapath. It sequences the serve, rally, point-hold, pause and game-over phases and gates the paddle and ball update engines with single-cycle enables. It owns both score counters and the serve-player selection. It sits between the button inputs, the goal detector and the paddle/ball/VGA blocks, and replaces free-running divided update clocks with enables on the system clock.

Parameters:
WIN_SCORE, 9, score at which a player wins (1..15)
POINT_FRAMES, 60, frame_tick count the field stays frozen after a goal (1..255)
BALL_DIV, 1, ball moves once every BALL_DIV frame_ticks (1..15)

Ports:
clk  in  1  system clock
Reset_n  in  1  asynchronous active-low reset
Reset  in  1  game restart button, raw, synchronous soft restart
Pause  in  1  pause button, raw
P1_Press  in  1  player 1 serve button, raw
P2_Press  in  1  player 2 serve button, raw
frame_tick  in  1  one-cycle pulse per video frame, clk domain
goal  in  2  0 none, 1 ball past P2 edge (P2 point), 2 ball past P1 edge (P1 point), 3 treated as 0
state  out  3  0 SERVE, 1 RALLY, 2 POINT, 3 PAUSED, 4 GAME_OVER
paddle_en  out  1  one-cycle paddle update enable
ball_en  out  1  one-cycle ball update enable
ball_hold  out  1  ball is glued to the serving paddle
serve_player  out  1  0 P1 serves, 1 P2 serves
p1_score  out  4  player 1 score
p2_score  out  4  player 2 score
winner  out  2  0 none, 1 P1, 2 P2

Behaviour:
- Reset_n low, asynchronous: state=SERVE, saved_state=SERVE, scores=0, winner=0, serve_player=0, paddle_en=0, ball_en=0, ball_hold=1, frame counters=0, synchronizer and edge flops=0.
- Reset, Pause, P1_Press, P2_Press: each passes through a 2-flop synchronizer, then a rising-edge detector.
  - A press is acted on at the 3rd rising clk edge after it is first sampled high.
  - Holding a button produces exactly one event.
- goal: edge-qualified internally. A goal event is goal in {1,2} with registered previous goal==0. A level held across many cycles scores exactly once.
- Soft restart (Reset edge) has highest priority in every state: scores=0, winner=0, serve_player=0, state=SERVE, counters cleared.
- SERVE:
  - ball_hold=1.
  - paddle_en pulses one cycle after each frame_tick.
  - ball_en=0.
  - A press edge from the serving player (P1_Press if serve_player=0, else P2_Press) moves to RALLY. The other player's press is ignored.
  - A Pause edge moves to PAUSED with saved_state=SERVE.
- RALLY:
  - ball_hold=0.
  - paddle_en pulses one cycle after each frame_tick.
  - ball_en pulses one cycle after every BALL_DIV-th frame_tick. The divider counter clears on entering RALLY.
  - On a goal event:
    - goal=2: p1_score+1, serve_player=0.
    - goal=1: p2_score+1, serve_player=1.
    - If the new score equals WIN_SCORE: winner is set (1 or 2) and state goes to GAME_OVER.
    - Otherwise state goes to POINT with point_cnt=POINT_FRAMES.
  - Goal event and Pause edge in the same cycle: the goal wins and the pause event is dropped.
  - A Pause edge with no goal moves to PAUSED with saved_state=RALLY.
- POINT:
  - All enables 0, ball_hold=0.
  - point_cnt decrements on each frame_tick. On the tick that takes it to 0, state goes to SERVE (ball_hold=1 the next cycle).
  - Pause and press events are ignored. Goal events are ignored.
- PAUSED:
  - All enables 0. ball_hold holds its value from saved_state.
  - A Pause edge returns to saved_state. The ball divider counter is not cleared on resume.
  - Goal events are ignored.
- GAME_OVER:
  - All enables 0. Scores and winner hold.
  - A P1_Press or P2_Press edge clears scores and winner, sets serve_player=0 and state=SERVE.
- Scores never exceed WIN_SCORE and never wrap.
- winner is registered and changes in the same cycle as the score that reaches WIN_SCORE.
- All outputs are registered. paddle_en and ball_en are never high for two consecutive cycles.

Test Plan:
1. Reset_n low then high; 3 frame_ticks -> state=0, ball_hold=1, 3 paddle_en pulses each 1 cycle after a tick, ball_en=0, scores 0/0.
2. SERVE, serve_player=0: P2_Press held 100 cycles -> state stays 0. P1_Press pulse -> state=1 on the 3rd clk edge; with BALL_DIV=2, ball_en pulses on every 2nd frame_tick.
3. RALLY: goal=2 held 50 cycles -> p1_score=1 exactly once, serve_player=0, state=2. After POINT_FRAMES=4 frame_ticks -> state=0.
4. Same cycle as the goal=1 event, a Pause edge arrives -> p2_score+1, serve_player=1, state=2, never 3.
5. RALLY, Pause edge -> state=3 and enables silent for 10 frame_ticks. Second Pause edge -> state=1 and ball_en resumes.
6. p2_score=8, goal=1 event (WIN_SCORE=9) -> p2_score=9, winner=2, state=4. P1_Press edge -> scores 0/0, winner=0, state=0. Also assert Reset_n low mid-RALLY -> all outputs at reset values immediately, without a clock.

Source files
------------

// File: rtl/pong_game_sequencer_if.sv
// Control/status bundle between the Pong game-flow sequencer and the
// button, goal-detector and paddle/ball/VGA blocks around it.
interface pong_game_sequencer_if;
  logic       Reset;
  logic       Pause;
  logic       P1_Press;
  logic       P2_Press;
  logic       frame_tick;
  logic [1:0] goal;
  logic [2:0] state;
  logic       paddle_en;
  logic       ball_en;
  logic       ball_hold;
  logic       serve_player;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] winner;

  modport master (
    output Reset, Pause, P1_Press, P2_Press, frame_tick, goal,
    input  state, paddle_en, ball_en, ball_hold, serve_player,
           p1_score, p2_score, winner
  );

  modport slave (
    input  Reset, Pause, P1_Press, P2_Press, frame_tick, goal,
    output state, paddle_en, ball_en, ball_hold, serve_player,
           p1_score, p2_score, winner
  );
endinterface

// File: rtl/pong_game_sequencer.sv
// Pong game-flow controller: sequences serve/rally/point/pause/game-over,
// owns the scores and serve selection, and issues paddle/ball update enables.
module pong_game_sequencer #(
  parameter int WIN_SCORE    = 9,
  parameter int POINT_FRAMES = 60,
  parameter int BALL_DIV     = 1
) (
  input logic                  clk,
  input logic                  Reset_n,
  pong_game_sequencer_if.slave bus
);
  typedef enum logic [2:0] {
    S_SERVE  = 3'd0,
    S_RALLY  = 3'd1,
    S_POINT  = 3'd2,
    S_PAUSED = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [3:0] WIN_L   = 4'(WIN_SCORE);
  localparam logic [7:0] POINT_L = 8'(POINT_FRAMES);
  localparam logic [3:0] DIV_L   = 4'(BALL_DIV - 1);

  // Button bit order: [3] Reset, [2] Pause, [1] P1_Press, [0] P2_Press
  logic [3:0] btn_p0, btn_p1, btn_p2, btn_ev;
  logic [1:0] goal_v, goal_prev;
  logic       goal_ev, serve_ev;

  state_t     state_q, state_d, saved_q, saved_d;
  logic [3:0] p1_q, p1_d, p2_q, p2_d;
  logic [1:0] win_q, win_d;
  logic       serve_q, serve_d;
  logic       pad_q, pad_d, ball_q, ball_d, hold_q, hold_d;
  logic [7:0] point_q, point_d;
  logic [3:0] div_q, div_d;

  assign btn_ev  = btn_p1 & ~btn_p2;
  assign goal_v  = (bus.goal == 2'd3) ? 2'd0 : bus.goal;
  assign goal_ev = (goal_v != 2'd0) && (goal_prev == 2'd0);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      btn_p0    <= '0;
      btn_p1    <= '0;
      btn_p2    <= '0;
      goal_prev <= '0;
      state_q   <= S_SERVE;
      saved_q   <= S_SERVE;
      p1_q      <= '0;
      p2_q      <= '0;
      win_q     <= '0;
      serve_q   <= 1'b0;
      pad_q     <= 1'b0;
      ball_q    <= 1'b0;
      hold_q    <= 1'b1;
      point_q   <= '0;
      div_q     <= '0;
    end else begin
      // Two synchronizer stages, then the previous-value flop for edge detection
      btn_p0    <= {bus.Reset, bus.Pause, bus.P1_Press, bus.P2_Press};
      btn_p1    <= btn_p0;
      btn_p2    <= btn_p1;
      goal_prev <= goal_v;
      state_q   <= state_d;
      saved_q   <= saved_d;
      p1_q      <= p1_d;
      p2_q      <= p2_d;
      win_q     <= win_d;
      serve_q   <= serve_d;
      pad_q     <= pad_d;
      ball_q    <= ball_d;
      hold_q    <= hold_d;
      point_q   <= point_d;
      div_q     <= div_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    saved_d  = saved_q;
    p1_d     = p1_q;
    p2_d     = p2_q;
    win_d    = win_q;
    serve_d  = serve_q;
    point_d  = point_q;
    div_d    = div_q;
    pad_d    = 1'b0;
    ball_d   = 1'b0;
    serve_ev = serve_q ? btn_ev[0] : btn_ev[1];
    if (btn_ev[3]) begin
      state_d = S_SERVE;
      saved_d = S_SERVE;
      p1_d    = '0;
      p2_d    = '0;
      win_d   = '0;
      serve_d = 1'b0;
      point_d = '0;
      div_d   = '0;
    end else begin
      unique case (state_q)
        S_SERVE: begin
          pad_d = bus.frame_tick & ~pad_q;
          if (serve_ev) begin
            state_d = S_RALLY;
            div_d   = '0;
          end else if (btn_ev[2]) begin
            state_d = S_PAUSED;
            saved_d = S_SERVE;
          end
        end
        S_RALLY: begin
          pad_d = bus.frame_tick & ~pad_q;
          if (bus.frame_tick) begin
            if (div_q == DIV_L) begin
              div_d  = '0;
              ball_d = ~ball_q;
            end else begin
              div_d = div_q + 4'd1;
            end
          end
          // A goal outranks a simultaneous pause; the pause is simply lost
          if (goal_ev) begin
            if (goal_v == 2'd2) begin
              p1_d    = p1_q + 4'd1;
              serve_d = 1'b0;
              if (p1_d == WIN_L) win_d = 2'd1;
            end else begin
              p2_d    = p2_q + 4'd1;
              serve_d = 1'b1;
              if (p2_d == WIN_L) win_d = 2'd2;
            end
            if (win_d != 2'd0) begin
              state_d = S_OVER;
            end else begin
              state_d = S_POINT;
              point_d = POINT_L;
            end
          end else if (btn_ev[2]) begin
            state_d = S_PAUSED;
            saved_d = S_RALLY;
          end
        end
        S_POINT: begin
          if (bus.frame_tick) begin
            point_d = point_q - 8'd1;
            if (point_q <= 8'd1) state_d = S_SERVE;
          end
        end
        S_PAUSED: begin
          if (btn_ev[2]) state_d = saved_q;
        end
        S_OVER: begin
          if (btn_ev[1] || btn_ev[0]) begin
            state_d = S_SERVE;
            p1_d    = '0;
            p2_d    = '0;
            win_d   = '0;
            serve_d = 1'b0;
          end
        end
        default: state_d = S_SERVE;
      endcase
    end
    hold_d = (state_d == S_SERVE) || ((state_d == S_PAUSED) && (saved_d == S_SERVE));
  end

  assign bus.state        = state_q;
  assign bus.paddle_en    = pad_q;
  assign bus.ball_en      = ball_q;
  assign bus.ball_hold    = hold_q;
  assign bus.serve_player = serve_q;
  assign bus.p1_score     = p1_q;
  assign bus.p2_score     = p2_q;
  assign bus.winner       = win_q;
endmodule
